// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter with a small TX FIFO. Sends
//            DATA_BITS words LSB-first with start bit, optional parity and
//            1 or 2 stop bits; each bit lasts OVERSAMPLE quick_clk cycles.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          reset,
  input  logic                          quick_clk,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_en,
  output logic                          tx_ready,
  output logic                          tx_status,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic                          uart_tx
);

  localparam int c_CW = $clog2(OVERSAMPLE);
  localparam int c_PW = $clog2(FIFO_DEPTH);
  localparam int c_FW = c_PW + 1;

  localparam logic [c_CW-1:0] c_OS_LAST   = c_CW'(OVERSAMPLE - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
  localparam logic [3:0]      c_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      c_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [c_FW-1:0] c_DEPTH     = c_FW'(FIFO_DEPTH);
  localparam logic [c_FW-1:0] c_FCNT_ONE  = c_FW'(1);
  localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
  localparam logic            c_ODD       = (PARITY == 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [c_CW-1:0]      cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [c_PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [c_FW-1:0]      count_q, count_d;
  logic                 tx_q, tx_d;
  logic                 status_q, status_d;
  logic                 ready_q, ready_d;
  logic                 ovf_q, ovf_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic                 w_push, w_drop, w_pop, w_has, w_bit_end, w_head_par;
  logic [DATA_BITS-1:0] w_head;

  // Full/empty decisions use the pre-edge count, so a same-cycle pop never makes room.
  assign w_push     = tx_en && (count_q != c_DEPTH);
  assign w_drop     = tx_en && (count_q == c_DEPTH);
  assign w_has      = (count_q != '0);
  assign w_head     = mem_q[rd_ptr_q];
  assign w_head_par = (^w_head) ^ c_ODD;
  assign w_bit_end  = (cnt_q == c_OS_LAST);

  assign uart_tx    = tx_q;
  assign tx_status  = status_q;
  assign tx_ready   = ready_q;
  assign overflow   = ovf_q;
  assign fifo_count = count_q;

  // FIFO storage: no reset needed, pointers define validity.
  always_ff @(posedge quick_clk) begin
    if (w_push) mem_q[wr_ptr_q] <= tx_data;
  end

  // State and datapath registers; reset aborts any frame and empties the FIFO.
  always_ff @(posedge quick_clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_q     <= 1'b1;
      status_q <= 1'b1;
      ready_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      if (w_push) wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      count_q  <= count_d;
      tx_q     <= tx_d;
      status_q <= status_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state: bit timing, bit sequencing and FIFO pops (back-to-back from STOP).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + c_CNT_ONE;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    w_pop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (w_has) begin
          w_pop   = 1'b1;
          state_d = S_START;
          shift_d = w_head;
          par_d   = w_head_par;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (bit_q == c_DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      S_PAR: begin
        if (w_bit_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          cnt_d = '0;
          if (bit_q == c_STOP_LAST) begin
            bit_d = '0;
            if (w_has) begin
              w_pop   = 1'b1;
              state_d = S_START;
              shift_d = w_head;
              par_d   = w_head_par;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Outputs: computed from next state so the line and flags are registered.
  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + c_FCNT_ONE;
      2'b01:   count_d = count_q - c_FCNT_ONE;
      default: count_d = count_q;
    endcase
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      S_PAR:   tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
    status_d = (state_d == S_IDLE) && (count_d == '0);
    ready_d  = (count_d != c_DEPTH);
    if (w_drop)            ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
    else                   ovf_d = ovf_q;
  end

endmodule
`default_nettype wire
